// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor; SERIAL_SUB_OVF_EN adds the Ovf output
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             Borr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             d_bit;
    logic             bout;
    logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out of a_sr/b_sr, so keep them for the overflow test.
    logic             a_msb;
    logic             b_msb;
`endif

    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ bor;
        bout     = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
        res_next = {d_bit, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            bor    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Borr   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        bor   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                    end
                end
                S_SHIFT: begin
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    bor    <= bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Diff  <= res_next;
                        Borr  <= bout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        Ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borr;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    int asserts = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
`ifdef SERIAL_SUB_OVF_EN
        .Ovf   (Ovf),
`endif
        .Borr  (Borr)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_diff(input int a, input int b);
        int r;
        r = (a - b + 256) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic ref_borr(input int a, input int b);
        return a < b;
    endfunction

    function automatic logic ref_ovf(input int a, input int b);
        int sa, sb, r;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r  = sa - sb;
        return (r > 127) || (r < -128);
    endfunction

    // Launch one operation; operands are scrambled right after acceptance.
    task automatic do_op(input int a, input int b, output int lat, output int busy_cyc,
                         output int pulses);
        @(posedge clk); #1;
        A = a[W-1:0]; B = b[W-1:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom);
        busy_cyc = busy ? 1 : 0;
        lat = -1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        asserts++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
        end
        asserts++;
        if (Diff !== 8'h00 || Borr !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: Diff=%h Borr=%b required 00 0", Diff, Borr);
        end
`ifdef SERIAL_SUB_OVF_EN
        asserts++;
        if (Ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: Ovf=%b required 0", Ovf);
        end
`endif
    endtask

    task automatic test_basic;
        int lat, bc, np;
        do_op(8'h09, 8'h03, lat, bc, np);
        asserts++;
        if (lat !== W || np !== 1) begin
            failures++;
            $display("FAIL basic_latency: latency=%0d pulses=%0d required %0d 1", lat, np, W);
        end
        asserts++;
        if (bc !== W) begin
            failures++;
            $display("FAIL basic_busy: busy cycles=%0d required %0d", bc, W);
        end
        asserts++;
        if (Diff !== 8'h06 || Borr !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: Diff=%h Borr=%b required 06 0", Diff, Borr);
        end
    endtask

    task automatic test_borrow;
        int lat, bc, np;
        do_op(8'h03, 8'h09, lat, bc, np);
        asserts++;
        if (Diff !== 8'hFA || Borr !== 1'b1) begin
            failures++;
            $display("FAIL borrow_neg: Diff=%h Borr=%b required fa 1", Diff, Borr);
        end
        do_op(8'hFF, 8'hFF, lat, bc, np);
        asserts++;
        if (Diff !== 8'h00 || Borr !== 1'b0) begin
            failures++;
            $display("FAIL borrow_equal: Diff=%h Borr=%b required 00 0", Diff, Borr);
        end
    endtask

    task automatic test_ignore_start;
        int np;
        np = 0;
        @(posedge clk); #1;
        A = 8'h09; B = 8'h03; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3 || k == 8) begin
                A = 8'h55; B = 8'h11; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) np++;
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        asserts++;
        if (np !== 1) begin
            failures++;
            $display("FAIL ignore_pulses: done pulses=%0d required 1", np);
        end
        asserts++;
        if (Diff !== 8'h06 || Borr !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: Diff=%h Borr=%b required 06 0", Diff, Borr);
        end
    endtask

    task automatic test_abort;
        int np, lat, bc;
        np = 0;
        @(posedge clk); #1;
        A = 8'h09; B = 8'h03; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        asserts++;
        if (busy !== 1'b0 || Diff !== 8'h00 || Borr !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: busy=%b Diff=%h Borr=%b required 0 00 0", busy, Diff, Borr);
        end
        for (int k = 0; k < 12; k++) begin
            if (done) np++;
            @(posedge clk); #1;
        end
        asserts++;
        if (np !== 0) begin
            failures++;
            $display("FAIL abort_done: done pulses=%0d required 0", np);
        end
        do_op(8'h30, 8'h05, lat, bc, np);
        asserts++;
        if (Diff !== 8'h2B || Borr !== 1'b0 || lat !== W) begin
            failures++;
            $display("FAIL abort_restart: Diff=%h Borr=%b latency=%0d required 2b 0 %0d", Diff, Borr, lat, W);
        end
    endtask

    task automatic test_back_to_back;
        int e1, e2;
        e1 = -1; e2 = -1;
        @(posedge clk); #1;
        A = 8'h20; B = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (e1 < 0) begin
                    e1 = k;
                    asserts++;
                    if (Diff !== 8'h10 || Borr !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_first: Diff=%h Borr=%b required 10 0", Diff, Borr);
                    end
                    A = 8'h10; B = 8'h20;
                end else if (e2 < 0) begin
                    e2 = k;
                    asserts++;
                    if (Diff !== 8'hF0 || Borr !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_second: Diff=%h Borr=%b required f0 1", Diff, Borr);
                    end
                end
            end
            if (k == W + 2) start = 1'b0;
        end
        start = 1'b0;
        asserts++;
        if (e1 !== W || e2 - e1 !== W + 2) begin
            failures++;
            $display("FAIL b2b_spacing: first=%0d spacing=%0d required %0d %0d", e1, e2 - e1, W, W + 2);
        end
    endtask

    task automatic test_random;
        int a, b, lat, bc, np;
        logic [W-1:0] exp_d;
        for (int n = 0; n < 24; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (n == 0) begin a = 0; b = 255; end
            if (n == 1) begin a = 255; b = 0; end
            exp_d = ref_diff(a, b);
            do_op(a, b, lat, bc, np);
            asserts++;
            if (Diff !== exp_d || Borr !== ref_borr(a, b) || lat !== W || np !== 1) begin
                failures++;
                $display("FAIL random_op: A=%h B=%h Diff=%h Borr=%b lat=%0d pulses=%0d required %h %b %0d 1",
                         a[7:0], b[7:0], Diff, Borr, lat, np, exp_d, ref_borr(a, b), W);
            end
`ifdef SERIAL_SUB_OVF_EN
            asserts++;
            if (Ovf !== ref_ovf(a, b)) begin
                failures++;
                $display("FAIL random_ovf: A=%h B=%h Ovf=%b required %b", a[7:0], b[7:0], Ovf, ref_ovf(a, b));
            end
`endif
            repeat (3) begin
                @(posedge clk); #1;
                A = W'($urandom); B = W'($urandom);
            end
            asserts++;
            if (Diff !== exp_d || Borr !== ref_borr(a, b)) begin
                failures++;
                $display("FAIL random_hold: Diff=%h Borr=%b required %h %b", Diff, Borr, exp_d, ref_borr(a, b));
            end
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int lat, bc, np;
        do_op(8'h80, 8'h01, lat, bc, np);
        asserts++;
        if (Diff !== 8'h7F || Borr !== 1'b0 || Ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: Diff=%h Borr=%b Ovf=%b required 7f 0 1", Diff, Borr, Ovf);
        end
        do_op(8'h05, 8'h03, lat, bc, np);
        asserts++;
        if (Diff !== 8'h02 || Ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: Diff=%h Ovf=%b required 02 0", Diff, Ovf);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_borrow;
        test_ignore_start;
        test_abort;
        test_back_to_back;
        test_random;
`ifdef SERIAL_SUB_OVF_EN
        test_ovf;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH, minuend; captured on the edge that accepts start.
REQ-006 The block SHALL have port B, input, WIDTH, subtrahend; captured on the edge that accepts start.
REQ-007 The block SHALL have port busy, output, 1; high while in SHIFT.
REQ-008 The block SHALL have port done, output, 1; single-cycle completion pulse.
REQ-009 The block SHALL have port Diff, output, WIDTH, registered result of A-B modulo 2^WIDTH.
REQ-010 The block SHALL have port Borr, output, 1, registered final borrow-out (1 when A<B unsigned).

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT, DONE; all outputs driven from registers.
REQ-012 IDLE with start=1 SHALL: load A and B into internal shift registers; clear the borrow flip-flop and the bit counter; go to SHIFT.
REQ-013 IDLE with start=0 SHALL stay in IDLE with no change to Diff/Borr.
REQ-014 Each SHIFT cycle SHALL process one LSB-first bit: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
REQ-015 Each SHIFT cycle SHALL shift d into the MSB of the internal result register, shift both operand registers right by one, and store bout in the borrow flip-flop.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of width clog2(WIDTH+1).
REQ-017 On the WIDTH-th SHIFT edge the block SHALL copy the completed result to Diff, copy the final borrow to Borr, set done=1, and go to DONE.
REQ-018 Latency SHALL be: done rises on the WIDTH-th rising edge after the edge that sampled start.
REQ-019 DONE SHALL last one cycle, after which the FSM SHALL go to IDLE with done=0; done SHALL never be high for two consecutive cycles.
REQ-020 start in SHIFT or DONE SHALL be ignored: no reload and no queuing.
REQ-021 A and B changing after acceptance SHALL NOT affect the result in progress.
REQ-022 Diff and Borr SHALL hold their last values until the next completion.
REQ-023 Back-to-back operation SHALL be possible: a start sampled in the IDLE cycle right after DONE SHALL be accepted, giving a throughput of WIDTH+2 cycles per operation.

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, Diff=0, Borr=0, and clear the shift registers, counter and borrow flip-flop.
REQ-025 Reset SHALL take priority over start and over any in-progress SHIFT; an aborted operation SHALL produce no done pulse and SHALL leave Diff/Borr=0.
REQ-026 Reset SHALL have no asynchronous effect: outputs SHALL change only at a clock edge.

Configuration
REQ-027 When macro SERIAL_SUB_OVF_EN is defined, the block SHALL add output port Ovf, 1 bit, registered, reset 0.
REQ-028 Ovf SHALL be set at completion to the two's-complement signed overflow of A-B: (A[MSB]!=B[MSB]) && (Diff[MSB]!=A[MSB]); it SHALL hold like Diff.
REQ-029 When SERIAL_SUB_OVF_EN is undefined, port Ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8 unless stated)
REQ-030 Bench SHALL cover: A=0x09, B=0x03, start pulse -> done 8 edges later, Diff=0x06, Borr=0, busy high for 8 cycles.
REQ-031 Bench SHALL cover: A=0x03, B=0x09 -> Diff=0xFA, Borr=1; then A=0xFF, B=0xFF -> Diff=0x00, Borr=0.
REQ-032 Bench SHALL cover: start re-asserted with A=0x55, B=0x11 during SHIFT of 0x09-0x03 -> result is still 0x06, and there is exactly one done pulse.
REQ-033 Bench SHALL cover: rst_n=0 for one cycle at SHIFT cycle 4 -> busy=0, done never pulses, Diff=0x00, Borr=0; a fresh start then completes normally.
REQ-034 Bench SHALL cover: back-to-back starts 0x20-0x10 then 0x10-0x20 -> Diff=0x10/Borr=0, then Diff=0xF0/Borr=1, with done pulses 10 cycles apart.
REQ-035 Bench SHALL cover, with SERIAL_SUB_OVF_EN: A=0x80, B=0x01 -> Diff=0x7F, Borr=0, Ovf=1; and A=0x05, B=0x03 -> Ovf=0.
